// File: rtl/trdb_branch_map_unpacker_pkg.sv
// Shared types and default sizing for the trace-decoder branch-map unpacker.
package trdb_branch_map_unpacker_pkg;

    // Maximum branches per map (E-trace full map).
    localparam int TRDB_MAP_LEN = 31;
    // Branch-count field width; 2**TRDB_CNT_W must exceed TRDB_MAP_LEN.
    localparam int TRDB_CNT_W   = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        REPLAY = 1'b1
    } branch_map_state_e;

    typedef struct packed {
        logic [TRDB_CNT_W-1:0]   branches;
        logic [TRDB_MAP_LEN-1:0] map;
    } branch_map_pkt_t;

endpackage

// File: rtl/trdb_branch_map_unpacker_if.sv
// Packet-side and walker-side handshake bundle of the branch-map unpacker.
interface trdb_branch_map_unpacker_if
    import trdb_branch_map_unpacker_pkg::*;
#(
    parameter int MAP_LEN = TRDB_MAP_LEN,
    parameter int CNT_W   = TRDB_CNT_W
);
    // payload from the packet parser
    logic               pkt_valid_i;
    logic               pkt_ready_o;
    logic [CNT_W-1:0]   pkt_branches_i;
    logic [MAP_LEN-1:0] pkt_map_i;
    // per-branch outcomes to the instruction walker
    logic               br_valid_o;
    logic               br_ready_i;
    logic               br_taken_o;
    logic               br_last_o;
    logic [CNT_W-1:0]   br_remaining_o;
    logic               map_done_o;

    // Environment side: drives payloads and walker ready.
    modport master (
        output pkt_valid_i, pkt_branches_i, pkt_map_i, br_ready_i,
        input  pkt_ready_o, br_valid_o, br_taken_o, br_last_o,
               br_remaining_o, map_done_o
    );

    // Unpacker side.
    modport slave (
        input  pkt_valid_i, pkt_branches_i, pkt_map_i, br_ready_i,
        output pkt_ready_o, br_valid_o, br_taken_o, br_last_o,
               br_remaining_o, map_done_o
    );
endinterface

// File: rtl/trdb_branch_map_unpacker.sv
// Replays a branch-map payload one outcome at a time to the PC walker.
// A shift register holds the outcome bits (oldest at bit 0), a down-counter
// tracks how many are still to be presented, and a two-state FSM sequences it.
module trdb_branch_map_unpacker
    import trdb_branch_map_unpacker_pkg::*;
#(
    parameter int MAP_LEN = TRDB_MAP_LEN,
    parameter int CNT_W   = TRDB_CNT_W
)(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    trdb_branch_map_unpacker_if.slave bus
);

    branch_map_state_e  r_state;
    logic [MAP_LEN-1:0] r_map;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_map_done;

    logic               w_valid;
    logic               w_last;
    logic               w_consume;
    logic               w_ready;
    logic               w_accept;
    logic [CNT_W:0]     w_cnt_ext;
    logic [CNT_W-1:0]   w_load_cnt;

    assign w_valid   = (r_state == REPLAY);
    assign w_last    = w_valid && (r_remaining == CNT_W'(1));
    assign w_consume = w_valid && bus.br_ready_i;
    // Ready combinationally on the last consume so consecutive maps need no bubble.
    assign w_ready   = !flush_i && ((r_state == IDLE) || (w_consume && w_last));
    assign w_accept  = bus.pkt_valid_i && w_ready;
    assign w_cnt_ext = {1'b0, bus.pkt_branches_i};

    // Decode the count field: zero means a full map, oversized counts clamp to MAP_LEN.
    always_comb begin
        w_load_cnt = bus.pkt_branches_i;
        if (w_cnt_ext == '0) begin
            w_load_cnt = CNT_W'(MAP_LEN);
        end else if (w_cnt_ext > (CNT_W+1)'(MAP_LEN)) begin
            w_load_cnt = CNT_W'(MAP_LEN);
        end else begin
            w_load_cnt = bus.pkt_branches_i;
        end
    end

    // FSM, outcome shift register, down-counter and done pulse; flush overrides all.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_map       <= '0;
            r_remaining <= '0;
            r_map_done  <= 1'b0;
        end else if (flush_i) begin
            r_state     <= IDLE;
            r_map       <= '0;
            r_remaining <= '0;
            r_map_done  <= 1'b0;
        end else begin
            r_map_done <= w_consume && w_last;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_map       <= bus.pkt_map_i;
                        r_remaining <= w_load_cnt;
                        r_state     <= REPLAY;
                    end else begin
                        r_state     <= IDLE;
                    end
                end
                REPLAY: begin
                    if (w_accept) begin
                        // only possible while the last branch is consumed: reload wins
                        r_map       <= bus.pkt_map_i;
                        r_remaining <= w_load_cnt;
                        r_state     <= REPLAY;
                    end else if (w_consume) begin
                        r_map       <= r_map >> 1;
                        r_remaining <= r_remaining - CNT_W'(1);
                        r_state     <= w_last ? IDLE : REPLAY;
                    end else begin
                        r_state     <= REPLAY;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_map       <= '0;
                    r_remaining <= '0;
                end
            endcase
        end
    end

    assign bus.pkt_ready_o    = w_ready;
    assign bus.br_valid_o     = w_valid;
    // E-trace map bits are 0 for taken; gate so idle leftovers never show.
    assign bus.br_taken_o     = w_valid && !r_map[0];
    assign bus.br_last_o      = w_last;
    assign bus.br_remaining_o = r_remaining;
    assign bus.map_done_o     = r_map_done;

endmodule

// File: tb/tb_trdb_branch_map_unpacker.sv
// Scoreboard bench for the branch-map unpacker: stimulus pushes expected
// outcomes, a monitor pops and compares on every consumed branch.
module tb_trdb_branch_map_unpacker;
    import trdb_branch_map_unpacker_pkg::*;

    localparam int ML = TRDB_MAP_LEN;
    localparam int CW = TRDB_CNT_W;

    typedef struct {
        logic taken;
        logic last;
        int   rem;
    } exp_t;

    logic clk;
    logic rst_ni;
    logic flush_i;

    int   checks;
    int   failures;
    int   done_exp;
    int   done_seen;
    logic done_pending;
    exp_t exp_q[$];

    trdb_branch_map_unpacker_if #(.MAP_LEN(ML), .CNT_W(CW)) bus ();

    trdb_branch_map_unpacker #(.MAP_LEN(ML), .CNT_W(CW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .flush_i(flush_i),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Offer a payload until accepted; on acceptance queue its expected outcomes.
    task automatic send(input logic [CW-1:0] br, input logic [ML-1:0] map);
        bit ok;
        int n;
        bus.pkt_valid_i    = 1'b1;
        bus.pkt_branches_i = br;
        bus.pkt_map_i      = map;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (bus.pkt_ready_o) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.pkt_valid_i = 1'b0;
        if (!ok) begin
            chk("accept_timeout", 0, 1);
        end else begin
            n = (br == '0) ? ML : int'(br);
            for (int i = 0; i < n; i++) begin
                exp_t e;
                e.taken = ~map[i];
                e.last  = (i == n - 1);
                e.rem   = n - i;
                exp_q.push_back(e);
            end
            done_exp++;
        end
    endtask

    // Wait until the DUT is idle and every expected outcome has been seen.
    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (!bus.br_valid_o && exp_q.size() == 0) ok = 1'b1;
        end
        if (!ok) chk(name, 0, 1);
    endtask

    // Monitor: checks every consumed outcome and the done pulse timing.
    always @(negedge clk) begin
        if (rst_ni) begin
            chk("map_done", int'(bus.map_done_o), int'(done_pending));
            if (bus.map_done_o) done_seen++;
            done_pending = 1'b0;
            if (bus.br_valid_o && bus.br_ready_i && !flush_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_branch", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("br_taken", int'(bus.br_taken_o), int'(e.taken));
                    chk("br_last", int'(bus.br_last_o), int'(e.last));
                    chk("br_remaining", int'(bus.br_remaining_o), e.rem);
                    done_pending = e.last;
                end
            end
        end else begin
            done_pending = 1'b0;
        end
    end

    initial begin
        checks = 0; failures = 0; done_exp = 0; done_seen = 0; done_pending = 1'b0;
        rst_ni = 1'b0; flush_i = 1'b0;
        bus.pkt_valid_i = 1'b0; bus.pkt_branches_i = '0; bus.pkt_map_i = '0;
        bus.br_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_ni = 1'b1;

        // reset / idle state
        @(negedge clk);
        chk("rst_pkt_ready", int'(bus.pkt_ready_o), 1);
        chk("rst_br_valid", int'(bus.br_valid_o), 0);
        chk("rst_br_remaining", int'(bus.br_remaining_o), 0);
        chk("rst_map_done", int'(bus.map_done_o), 0);
        chk("rst_br_taken", int'(bus.br_taken_o), 0);
        chk("rst_br_last", int'(bus.br_last_o), 0);
        @(posedge clk); #1;

        // three branches, map 0b010: taken, not-taken, taken
        bus.br_ready_i = 1'b1;
        send(5'd3, 31'b010);
        @(negedge clk);
        chk("latency1_valid", int'(bus.br_valid_o), 1);
        wait_idle("idle_timeout_map3");

        // full map: count 0, all ones -> 31 not-taken
        @(posedge clk); #1;
        send(5'd0, {ML{1'b1}});
        @(negedge clk);
        chk("full_first_remaining", int'(bus.br_remaining_o), ML);
        wait_idle("idle_timeout_full");

        // back-to-back: A (2 branches) then B (1 branch, taken) with no bubble
        @(posedge clk); #1;
        send(5'd2, 31'b01);
        send(5'd1, 31'b0);
        @(negedge clk);
        chk("b2b_valid", int'(bus.br_valid_o), 1);
        chk("b2b_remaining", int'(bus.br_remaining_o), 1);
        chk("b2b_taken", int'(bus.br_taken_o), 1);
        wait_idle("idle_timeout_b2b");

        // stall: walker not ready for 5 cycles, outputs must hold
        @(posedge clk); #1;
        bus.br_ready_i = 1'b0;
        send(5'd2, 31'b10);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", int'(bus.br_valid_o), 1);
            chk("stall_taken", int'(bus.br_taken_o), 1);
            chk("stall_last", int'(bus.br_last_o), 0);
            chk("stall_remaining", int'(bus.br_remaining_o), 2);
        end
        @(posedge clk); #1;
        bus.br_ready_i = 1'b1;
        wait_idle("idle_timeout_stall");

        // flush after two consumes, with a payload offered in the flush cycle
        @(posedge clk); #1;
        send(5'd5, 31'b10110);
        @(posedge clk);
        @(posedge clk); #1;
        flush_i = 1'b1;
        bus.pkt_valid_i = 1'b1; bus.pkt_branches_i = 5'd1; bus.pkt_map_i = 31'b1;
        exp_q.delete();
        done_exp--;
        @(negedge clk);
        chk("flush_pkt_ready", int'(bus.pkt_ready_o), 0);
        chk("flush_br_valid", int'(bus.br_valid_o), 1);
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("post_flush_valid", int'(bus.br_valid_o), 0);
        chk("post_flush_remaining", int'(bus.br_remaining_o), 0);
        chk("post_flush_pkt_ready", int'(bus.pkt_ready_o), 1);
        @(posedge clk); #1;
        bus.pkt_valid_i = 1'b0;
        begin
            exp_t e;
            e.taken = 1'b0; e.last = 1'b1; e.rem = 1;
            exp_q.push_back(e);
            done_exp++;
        end
        @(negedge clk);
        chk("post_flush_accepted", int'(bus.br_valid_o), 1);
        wait_idle("idle_timeout_flush");

        // asynchronous reset mid-replay drops the map immediately
        @(posedge clk); #1;
        bus.br_ready_i = 1'b0;
        send(5'd4, 31'b0);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("arst_br_valid", int'(bus.br_valid_o), 0);
        chk("arst_remaining", int'(bus.br_remaining_o), 0);
        chk("arst_pkt_ready", int'(bus.pkt_ready_o), 1);
        exp_q.delete();
        done_exp--;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        bus.br_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_stays_idle", int'(bus.br_valid_o), 0);

        chk("done_count", done_seen, done_exp);
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trdb_branch_map_unpacker.md
Name: trdb_branch_map_unpacker

Overview:
- Decoder-side counterpart of the encoder's branch detection and branch-map accumulation.
- Accepts branch-map payloads (branch count plus outcome bitmap) from the packet parser and replays them one branch at a time to the decoder's instruction walker.
- Each replayed branch carries a taken/not-taken flag.
- Sits between the packet deserializer and the PC-reconstruction walker in the trace decoder.

Parameters:
- MAP_LEN, 31, maximum branches per map (E-trace full map).
- CNT_W, 5, width of the branch-count field; must satisfy 2**CNT_W > MAP_LEN.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- flush_i  input  1  synchronous discard of the current map (decoder resync).
- pkt_valid_i  input  1  branch-map payload valid.
- pkt_ready_o  output  1  unpacker can accept a payload.
- pkt_branches_i  input  CNT_W  number of valid map bits; 0 encodes MAP_LEN (full map).
- pkt_map_i  input  MAP_LEN  outcome bits, bit 0 = oldest branch; 0 = taken, 1 = not taken (E-trace convention).
- br_valid_o  output  1  a branch outcome is presented.
- br_ready_i  input  1  walker consumes the outcome.
- br_taken_o  output  1  outcome of the presented branch (1 = taken).
- br_last_o  output  1  presented branch is the last one of the current map.
- br_remaining_o  output  CNT_W  branches left including the presented one; 0 when idle.
- map_done_o  output  1  one-cycle pulse the cycle after the last branch is consumed.

Behaviour:
- Reset values: state IDLE, map_q = 0, remaining_q = 0, br_valid_o = 0, br_taken_o = 0, br_last_o = 0, br_remaining_o = 0, map_done_o = 0. pkt_ready_o = 1 (IDLE and no flush).
- States: IDLE, REPLAY.
- br_valid_o = (state == REPLAY). br_taken_o = ~map_q[0] when valid, else 0. br_last_o = valid && remaining_q == 1.
- pkt_ready_o = !flush_i && (IDLE || (br_valid_o && br_ready_i && br_last_o)). This is combinational on br_ready_i, so back-to-back maps incur zero bubbles.
- Accept (pkt_valid_i && pkt_ready_o):
  - map_q <= pkt_map_i.
  - remaining_q <= (pkt_branches_i == 0) ? MAP_LEN : pkt_branches_i.
  - Next state is REPLAY.
  - First outcome is presented the cycle after acceptance (latency 1).
- Consume (br_valid_o && br_ready_i): map_q <= map_q >> 1 (zero fill); remaining_q <= remaining_q - 1.
  - If last and no accept: next state IDLE, map_done_o = 1 next cycle.
  - If last with accept in the same cycle: the accept load wins, state stays REPLAY, and map_done_o still pulses.
- Outputs are held stable while br_valid_o && !br_ready_i. The walker may stall indefinitely.
- Map bits at index >= count are ignored and never presented.
- pkt_branches_i > MAP_LEN is unreachable by width when MAP_LEN = 2**CNT_W - 1. For other MAP_LEN values it is clamped to MAP_LEN.
- flush_i has priority over everything:
  - Next state IDLE, remaining_q = 0, map_q = 0, no map_done_o pulse.
  - pkt_ready_o is 0 during the flush cycle, so no payload is lost.
  - br_valid_o is still combinationally 1 in the flush cycle if REPLAY. A consume in that cycle has no effect.
- Asynchronous reset mid-replay: all state is cleared immediately and the remaining branches are dropped.

Decomposition:
- trdb_pkg additions: MAP_LEN and CNT_W default constants; typedef enum logic {IDLE, REPLAY} branch_map_state_e; typedef struct packed {logic [CNT_W-1:0] branches; logic [MAP_LEN-1:0] map;} branch_map_pkt_t.
- Single module, no sub-module. The shift register, down-counter and 2-state FSM are small enough to keep flat.

Test Plan:
- Reset, then idle: pkt_ready_o = 1, br_valid_o = 0, br_remaining_o = 0, map_done_o = 0.
- Send branches = 3, map = 0b010, br_ready_i held 1:
  - Outcomes taken, not-taken, taken on cycles 1, 2, 3 after accept.
  - br_last_o only on cycle 3; br_remaining_o reads 3, 2, 1.
  - map_done_o pulses on cycle 4.
- Send branches = 0, map = all 1s: 31 not-taken outcomes, br_remaining_o starts at 31, br_last_o on the 31st outcome.
- Back-to-back: map A (branches = 2) then map B (branches = 1, map = 0) already valid:
  - B is accepted in the same cycle A's last branch is consumed.
  - B's taken outcome is presented the next cycle with no bubble.
  - map_done_o pulses once.
- Stall: branches = 2, br_ready_i = 0 for 5 cycles: br_taken_o, br_last_o and br_remaining_o = 2 stay stable; the first outcome is consumed when br_ready_i rises.
- Flush mid-map: branches = 5, consume 2, assert flush_i with pkt_valid_i = 1 in the same cycle:
  - Payload not accepted; IDLE next cycle, br_valid_o = 0, no map_done_o pulse.
  - Payload is accepted the following cycle.
